demux1to8_stream: RTL and testbench

- Distributor side of the 8:1 selection tree: takes one DATA_W-bit valid/ready stream and routes each word to one of N_OUT output channels by a per-word select.
- Every output channel has a one-entry register slice, so each output is registered and back-pressure is per channel.
- Sits where one producer feeds N_OUT independent consumers.

---
 rtl/demux1to8_stream_pkg.sv | 11 +
 rtl/demux1to8_stream_slot.sv | 40 ++++
 rtl/demux1to8_stream.sv | 77 +++++++
 tb/tb_demux1to8_stream.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/demux1to8_stream_pkg.sv
// Shared types and default sizes for the 1-to-8 stream distributor.
// Optional broadcast support is enabled in the top by defining DEMUX_BCAST_EN.
package demux_pkg;

   localparam int DEMUX_DATA_W = 8;
   localparam int DEMUX_N_OUT  = 8;

   typedef logic [2:0] demux_sel_t;
   typedef logic [7:0] demux_word_t;

endpackage

// File: rtl/demux1to8_stream_slot.sv
// One-entry output register slice: holds a word until its consumer takes it,
// and can accept a replacement in the same cycle the held word drains.
module demux_slot
   import demux_pkg::*;
#(
   parameter int DATA_W = DEMUX_DATA_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] data_in,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              slot_free
);

   logic              valid_r;
   logic [DATA_W-1:0] data_r;

   // Slot state: load wins over drain; data is kept after a drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= {DATA_W{1'b0}};
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= data_in;
      end else if (valid_r && out_ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign out_valid = valid_r;
   assign out_data  = data_r;
   assign slot_free = ~valid_r | out_ready;

endmodule

// File: rtl/demux1to8_stream.sv
// Routes one valid/ready stream to N_OUT registered output channels by in_sel.
// Define DEMUX_BCAST_EN to let in_bcast load every channel at once (all-or-nothing).
module demux1to8_stream
   import demux_pkg::*;
#(
   parameter  int DATA_W = DEMUX_DATA_W,
   parameter  int N_OUT  = DEMUX_N_OUT,
   localparam int SEL_W  = $clog2(N_OUT)
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_W-1:0]            in_data,
   input  logic [SEL_W-1:0]             in_sel,
   input  logic                         in_bcast,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [N_OUT-1:0][DATA_W-1:0] out_data,
   output logic [N_OUT-1:0]             out_valid,
   input  logic [N_OUT-1:0]             out_ready,
   output logic [N_OUT-1:0]             occ
);

   logic [N_OUT-1:0] slot_free_s;
   logic [N_OUT-1:0] load_s;
   logic             bcast_s;
   logic             ready_s;
   logic             xfer_s;

`ifdef DEMUX_BCAST_EN
   assign bcast_s = in_bcast;
`else
   logic bcast_unused_s;
   assign bcast_unused_s = in_bcast;
   assign bcast_s        = 1'b0;
`endif

   // Accept decision: a broadcast needs every slot free, unicast only its target.
   always_comb begin
      ready_s = 1'b0;
      if (rst) begin
         ready_s = 1'b0;
      end else if (bcast_s) begin
         ready_s = &slot_free_s;
      end else begin
         ready_s = slot_free_s[in_sel];
      end
   end

   assign xfer_s   = in_valid & ready_s;
   assign in_ready = ready_s;

   // Select decode: at most one slot loads per unicast transfer.
   always_comb begin
      load_s = {N_OUT{1'b0}};
      for (int k = 0; k < N_OUT; k++) begin
         load_s[k] = xfer_s & ((in_sel == SEL_W'(k)) | bcast_s);
      end
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_slot
      demux_slot #(
         .DATA_W(DATA_W)
      ) u_slot (
         .clk      (clk),
         .rst      (rst),
         .load     (load_s[g]),
         .data_in  (in_data),
         .out_ready(out_ready[g]),
         .out_valid(out_valid[g]),
         .out_data (out_data[g]),
         .slot_free(slot_free_s[g])
      );
   end

   assign occ = out_valid;

endmodule

// File: tb/tb_demux1to8_stream.sv
// Directed and scoreboarded checks for demux1to8_stream.
module tb_demux1to8_stream;
   import demux_pkg::*;

   logic             clk;
   logic             rst;
   demux_word_t      in_data;
   demux_sel_t       in_sel;
   logic             in_bcast;
   logic             in_valid;
   logic             in_ready;
   logic [7:0][7:0]  out_data;
   logic [7:0]       out_valid;
   logic [7:0]       out_ready;
   logic [7:0]       occ;

   int errors = 0;
   int checks = 0;

   demux1to8_stream dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_bcast (in_bcast),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .occ      (occ)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_sel = 3'd0; in_data = 8'hFF; out_ready = 8'h00;
      #2;
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h want 00", out_valid); end
      checks++; if (occ !== 8'h00) begin errors++; $display("FAIL reset_occ: got %h want 00", occ); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
      step(); rst = 1'b0; in_valid = 1'b0;
      step();
      in_valid = 1'b1; in_sel = 3'd2; in_data = 8'h22;
      step();
      in_sel = 3'd5; in_data = 8'h55;
      step();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 8'h24) begin errors++; $display("FAIL fill_2_5: got %h want 24", out_valid); end
      #2; rst = 1'b1; #1;
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL midrst_valid: got %h want 00", out_valid); end
      checks++; if (occ !== 8'h00) begin errors++; $display("FAIL midrst_occ: got %h want 00", occ); end
      checks++; if (out_data[2] !== 8'h00 || out_data[5] !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h/%h want 00/00", out_data[2], out_data[5]); end
      in_valid = 1'b1; in_sel = 3'd1; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
      step(); in_valid = 1'b0; rst = 1'b0;
      step();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL post_rst_valid: got %h want 00", out_valid); end
   endtask

   task automatic test_unicast();
      out_ready = 8'hFF; in_valid = 1'b1; in_sel = 3'd3; in_data = 8'hA5; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL uni_in_ready: got %b want 1", in_ready); end
      step(); in_valid = 1'b0;
      checks++; if (out_valid !== 8'h08) begin errors++; $display("FAIL uni_valid: got %h want 08", out_valid); end
      checks++; if (out_data[3] !== 8'hA5) begin errors++; $display("FAIL uni_data: got %h want a5", out_data[3]); end
      step();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL uni_drain: got %h want 00", out_valid); end
      checks++; if (out_data[3] !== 8'hA5) begin errors++; $display("FAIL uni_hold_data: got %h want a5", out_data[3]); end
   endtask

   task automatic test_backpressure();
      out_ready = 8'hBF; in_valid = 1'b1; in_sel = 3'd6; in_data = 8'h11; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
      step();
      in_data = 8'h22; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 8'h40 || out_data[6] !== 8'h11) begin errors++; $display("FAIL bp_slot6: got %h/%h want 40/11", out_valid, out_data[6]); end
      in_valid = 1'b0;
      step();
      in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h33; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_other_ready: got %b want 1", in_ready); end
      step(); in_valid = 1'b0;
      checks++; if (out_valid !== 8'h42 || out_data[1] !== 8'h33) begin errors++; $display("FAIL bp_other_load: got %h/%h want 42/33", out_valid, out_data[1]); end
      checks++; if (out_data[6] !== 8'h11) begin errors++; $display("FAIL bp_stall_hold: got %h want 11", out_data[6]); end
      out_ready = 8'hFF; in_valid = 1'b1; in_sel = 3'd6; in_data = 8'h22; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      step(); in_valid = 1'b0;
      checks++; if (out_valid !== 8'h40 || out_data[6] !== 8'h22) begin errors++; $display("FAIL bp_second_load: got %h/%h want 40/22", out_valid, out_data[6]); end
      step();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL bp_empty: got %h want 00", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 8'hFF; in_sel = 3'd0; in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
         @(posedge clk); #1;
         checks++; if (out_valid !== 8'h01 || out_data[0] !== 8'(i)) begin errors++; $display("FAIL b2b_out[%0d]: got %h/%h want 01/%h", i, out_valid, out_data[0], 8'(i)); end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_bcast();
      out_ready = 8'hEF; in_bcast = 1'b0; in_valid = 1'b1; in_sel = 3'd4; in_data = 8'h44;
      step();
`ifdef DEMUX_BCAST_EN
      in_bcast = 1'b1; in_sel = 3'd2; in_data = 8'h5A; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bcast_blocked: got %b want 0", in_ready); end
      step();
      checks++; if (out_valid !== 8'h10 || out_data[4] !== 8'h44) begin errors++; $display("FAIL bcast_no_change: got %h/%h want 10/44", out_valid, out_data[4]); end
      out_ready = 8'hFF; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bcast_release: got %b want 1", in_ready); end
      step(); in_valid = 1'b0; in_bcast = 1'b0;
      checks++; if (out_valid !== 8'hFF) begin errors++; $display("FAIL bcast_all_valid: got %h want ff", out_valid); end
      for (int k = 0; k < 8; k++) begin
         checks++; if (out_data[k] !== 8'h5A) begin errors++; $display("FAIL bcast_data[%0d]: got %h want 5a", k, out_data[k]); end
      end
`else
      in_bcast = 1'b1; in_sel = 3'd2; in_data = 8'h5A; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nobcast_ready: got %b want 1", in_ready); end
      step(); in_valid = 1'b0; in_bcast = 1'b0;
      checks++; if (out_valid !== 8'h14 || out_data[2] !== 8'h5A || out_data[4] !== 8'h44) begin errors++; $display("FAIL nobcast_unicast: got %h/%h/%h want 14/5a/44", out_valid, out_data[2], out_data[4]); end
      out_ready = 8'hFF;
`endif
      step();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL bcast_drained: got %h want 00", out_valid); end
   endtask

   task automatic test_random();
      logic [7:0] exp_data [8];
      logic [7:0] exp_full;
      logic       exp_rdy;
      int sent = 0;
      int cyc  = 0;
      exp_full = 8'h00;
      for (int k = 0; k < 8; k++) exp_data[k] = 8'h00;
      out_ready = 8'hFF; in_valid = 1'b0; in_bcast = 1'b0;
      step();
      while (sent < 10000 && cyc < 60000) begin
         out_ready = 8'($urandom);
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1; in_sel = 3'($urandom); in_data = 8'($urandom);
         end
         #1;
         exp_rdy = !exp_full[in_sel] || out_ready[in_sel];
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy); end
         checks++; if (out_valid !== exp_full) begin errors++; $display("FAIL rnd_valid c%0d: got %h want %h", cyc, out_valid, exp_full); end
         for (int k = 0; k < 8; k++) begin
            if (exp_full[k] && out_ready[k]) begin
               checks++; if (out_data[k] !== exp_data[k]) begin errors++; $display("FAIL rnd_data ch%0d c%0d: got %h want %h", k, cyc, out_data[k], exp_data[k]); end
               exp_full[k] = 1'b0;
            end
         end
         if (in_valid && exp_rdy) begin
            exp_full[in_sel] = 1'b1;
            exp_data[in_sel] = in_data;
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
         if (in_valid && exp_rdy) in_valid = 1'b0;
      end
      checks++; if (sent < 10000) begin errors++; $display("FAIL rnd_timeout: got %0d words want 10000", sent); end
      in_valid = 1'b0; out_ready = 8'hFF; #1;
      for (int k = 0; k < 8; k++) begin
         if (exp_full[k]) begin
            checks++; if (out_data[k] !== exp_data[k]) begin errors++; $display("FAIL rnd_tail ch%0d: got %h want %h", k, out_data[k], exp_data[k]); end
         end
      end
      step();
      checks++; if (out_valid !== 8'h00) begin errors++; $display("FAIL rnd_final_empty: got %h want 00", out_valid); end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_bcast = 1'b0;
      in_sel = 3'd0; in_data = 8'h00; out_ready = 8'h00;
      test_reset();
      test_unicast();
      test_backpressure();
      test_back_to_back();
      test_bcast();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
